alu_issue_seq: RTL and testbench

Instruction issue and writeback sequencer placed directly upstream of the 15-bit signed ALU. Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an 8-entry register file. Drives the ALU's A/B/command inputs, captures the ALU result, and writes it back. One instruction is in flight at a time. ALU ops take 3 cycles; LDI takes 1 cycle.

---
 rtl/alu_issue_seq.sv | 124 ++++++++++++
 tb/tb_alu_issue_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer for the 15-bit signed ALU: one instruction in flight, 8-entry rf.
// Define DIV_ZERO_TRAP_EN to trap zero-divisor DV0/DV1 locally and add the div_err output.
module alu_issue_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_cmd,
    input  logic [14:0] alu_result,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
`ifdef DIV_ZERO_TRAP_EN
    output logic        div_err,
`endif
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

    localparam logic [2:0] OpLdi = 3'd7;

    state_e      state_q;
    logic [15:0] rf_q [8];
    logic        from_alu_q;

    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] ldi_val;
    logic        accept;
    logic        trap;

    assign op      = instr[15:13];
    assign rd      = instr[12:10];
    assign rs1     = instr[9:7];
    assign rs2     = instr[6:4];
    assign ldi_val = {{5{instr[9]}}, instr[9:0], 1'b0};
    assign accept  = instr_valid && (state_q == StIdle);

`ifdef DIV_ZERO_TRAP_EN
    assign trap = ((op == 3'd5) || (op == 3'd6)) && (rf_q[rs2][15:1] == 15'd0);
`else
    assign trap = 1'b0;
`endif

    assign instr_ready = (state_q == StIdle);
    assign dbg_data    = rf_q[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            from_alu_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        wb_rd <= rd;
                        if (op == OpLdi) begin
                            state_q    <= StWb;
                            wb_valid   <= 1'b1;
                            wb_data    <= ldi_val;
                            from_alu_q <= 1'b0;
                        end else if (trap) begin
                            state_q    <= StWb;
                            wb_valid   <= 1'b1;
                            wb_data    <= 16'hFFFE;
                            from_alu_q <= 1'b0;
                        end else begin
                            state_q    <= StIssue;
                            alu_a      <= rf_q[rs1];
                            alu_b      <= rf_q[rs2];
                            alu_cmd    <= op;
                            from_alu_q <= 1'b1;
                        end
                    end
                end
                StIssue: state_q <= StWait;
                StWait: begin
                    state_q  <= StWb;
                    wb_valid <= 1'b1;
                    wb_data  <= {alu_result, 1'b0};
                end
                StWb: begin
                    state_q  <= StIdle;
                    wb_valid <= 1'b0;
                    // r0 stays hard-wired to zero; the pulse above still reports the write.
                    if (wb_rd != 3'd0) begin
                        rf_q[wb_rd] <= from_alu_q ? {alu_result, 1'b0} : wb_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_err <= 1'b0;
        end else begin
            div_err <= accept && trap;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized self-checking bench for alu_issue_seq with a transaction-level reference model
// and a behavioural ALU stub (negedge operand latch, posedge result).
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [14:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        div_err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

`ifdef DIV_ZERO_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
    assign div_err = 1'b0;
`endif

    alu_issue_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cmd     (alu_cmd),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`ifdef DIV_ZERO_TRAP_EN
        .div_err     (div_err),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural 15-bit signed ALU: operands in [15:1].
    function automatic logic [14:0] alu_fn(input logic [2:0] c, input logic [15:0] a,
                                           input logic [15:0] b);
        logic signed [14:0] xs;
        logic signed [14:0] ys;
        int x;
        int y;
        int r;
        logic [31:0] rv;
        xs = a[15:1];
        ys = b[15:1];
        x  = xs;
        y  = ys;
        case (c)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x * y;
            3'd4: r = (x * y) >>> 15;
            3'd5: r = (y == 0) ? 32'h7FFF : x / y;
            3'd6: r = (y == 0) ? 32'h7FFF : x % y;
            default: r = 0;
        endcase
        rv = r;
        return rv[14:0];
    endfunction

    logic [15:0] lat_a = '0;
    logic [15:0] lat_b = '0;
    logic [2:0]  lat_c = '0;

    initial forever begin
        @(negedge clk);
        lat_a = alu_a;
        lat_b = alu_b;
        lat_c = alu_cmd;
    end

    initial forever begin
        @(posedge clk);
        alu_result <= alu_fn(lat_c, lat_a, lat_b);
    end

    // Reference model: rem counts cycles until ready; the write is visible while rem==1.
    logic [15:0] rf_m [8];
    int          rem = 0;
    logic [2:0]  pend_rd = '0;
    logic [15:0] pend_data = '0;
    bit          pend_trap = 1'b0;
    logic [15:0] exp_a = '0;
    logic [15:0] exp_b = '0;
    logic [2:0]  exp_cmd = '0;
    int          acc_cnt = 0;
    int          wb_cnt = 0;

    initial forever begin
        logic [2:0] op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_m[i] = '0;
            rem       = 0;
            pend_trap = 1'b0;
            exp_a     = '0;
            exp_b     = '0;
            exp_cmd   = '0;
        end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0 && pend_rd != 3'd0) rf_m[pend_rd] = pend_data;
        end else if (instr_valid) begin
            acc_cnt++;
            op      = instr[15:13];
            rs1     = instr[9:7];
            rs2     = instr[6:4];
            pend_rd = instr[12:10];
            if (op == 3'd7) begin
                pend_data = {{5{instr[9]}}, instr[9:0], 1'b0};
                pend_trap = 1'b0;
                rem       = 1;
            end else if (Trap && (op == 3'd5 || op == 3'd6) && rf_m[rs2][15:1] == 15'd0) begin
                pend_data = 16'hFFFE;
                pend_trap = 1'b1;
                rem       = 1;
            end else begin
                exp_a     = rf_m[rs1];
                exp_b     = rf_m[rs2];
                exp_cmd   = op;
                pend_data = {alu_fn(op, rf_m[rs1], rf_m[rs2]), 1'b0};
                pend_trap = 1'b0;
                rem       = 3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("instr_ready", instr_ready, rem == 0);
            chk("wb_valid", wb_valid, rem == 1);
            if (rem == 1) begin
                chk("wb_rd", wb_rd, pend_rd);
                chk("wb_data", wb_data, pend_data);
            end
            chk("alu_a", alu_a, exp_a);
            chk("alu_b", alu_b, exp_b);
            chk("alu_cmd", alu_cmd, exp_cmd);
            chk("dbg_data", dbg_data, rf_m[dbg_addr]);
            if (Trap) chk("div_err", div_err, (rem == 1) && pend_trap);
            if (wb_valid === 1'b1) wb_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dbg_addr = 3'($urandom);
        end
    endtask

    task automatic send(input logic [15:0] w, input bit hold);
        int a0;
        bit got;
        a0          = acc_cnt;
        got         = 1'b0;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            dbg_addr = 3'($urandom);
            if (acc_cnt != a0) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string name);
        dbg_addr = r;
        #1;
        chk(name, dbg_data, exp);
    endtask

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'd7, rd, imm};
    endfunction

    function automatic logic [15:0] aop(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'd0};
    endfunction

    initial begin
        int wb0;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_cmd", alu_cmd, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        rst_n = 1'b1;
        idle(1);

        send(ldi(3'd1, 10'd5), 1'b0);
        send(ldi(3'd2, 10'd3), 1'b0);
        idle(1);
        peek(3'd1, 16'h000A, "r1_ldi");
        peek(3'd2, 16'h0006, "r2_ldi");

        send(aop(3'd0, 3'd3, 3'd1, 3'd2), 1'b0);
        chk("add_alu_a", alu_a, 16'h000A);
        chk("add_alu_b", alu_b, 16'h0006);
        chk("add_alu_cmd", alu_cmd, 0);
        idle(2);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_rd", wb_rd, 3);
        chk("add_wb_data", wb_data, 16'h0010);
        idle(1);
        chk("add_ready", instr_ready, 1);
        peek(3'd3, 16'h0010, "r3_add");

        send(ldi(3'd4, 10'h3FE), 1'b0);
        idle(1);
        peek(3'd4, 16'hFFFC, "r4_neg");
        send(aop(3'd1, 3'd5, 3'd2, 3'd1), 1'b0);
        chk("sub_alu_cmd", alu_cmd, 1);
        idle(3);
        peek(3'd5, 16'hFFFC, "r5_sub");

        wb0 = wb_cnt;
        send(aop(3'd0, 3'd5, 3'd1, 3'd1), 1'b1);
        send(aop(3'd0, 3'd6, 3'd2, 3'd2), 1'b1);
        send(aop(3'd0, 3'd7, 3'd1, 3'd2), 1'b0);
        idle(4);
        chk("bp_wb_pulses", wb_cnt - wb0, 3);
        peek(3'd7, 16'h0010, "r7_bp");

        send(ldi(3'd0, 10'd7), 1'b0);
        chk("r0_wb_valid", wb_valid, 1);
        chk("r0_wb_rd", wb_rd, 0);
        chk("r0_wb_data", wb_data, 16'h000E);
        idle(1);
        peek(3'd0, 16'h0000, "r0_read");

        send(aop(3'd5, 3'd7, 3'd1, 3'd0), 1'b0);
        chk("dv0_alu_cmd", alu_cmd, Trap ? 32'd0 : 32'd5);
        if (Trap) chk("dv0_div_err", div_err, 1);
        idle(3);
        peek(3'd7, 16'hFFFE, "r7_dv0");

        send(aop(3'd0, 3'd6, 3'd1, 3'd2), 1'b0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", instr_ready, 1);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0);
        chk("mid_wb_valid", wb_valid, 0);
        chk("mid_wb_rd", wb_rd, 0);
        peek(3'd6, 16'h0000, "mid_r6");
        peek(3'd1, 16'h0000, "mid_r1");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2);
        peek(3'd6, 16'h0000, "post_r6");

        for (int k = 0; k < 300; k++) begin
            logic [2:0] op;
            bit hold;
            op   = 3'($urandom_range(0, 9) > 6 ? 7 : $urandom_range(0, 6));
            hold = 1'($urandom_range(0, 1));
            if (op == 3'd7) send(ldi(3'($urandom), 10'($urandom)), hold);
            else send(aop(op, 3'($urandom), 3'($urandom), 3'($urandom)), hold);
            if (!hold) idle($urandom_range(0, 2));
        end
        instr_valid = 1'b0;
        idle(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
